prj_processor_button_poller: RTL and testbench

- Avalon-MM read master that periodically polls the 2-bit Buttons PIO slave, which has readdata registered with a fixed read latency of 1.
- Debounces the sampled bits and detects press/release edges.
- Presents edge events to the fabric through a valid/ready handshake.
- Sits between the Buttons PIO slave and the control logic that consumes button events.

---
 rtl/prj_processor_button_poller.sv | 158 +++++++++++++++
 tb/tb_prj_processor_button_poller.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prj_processor_button_poller.sv
`default_nettype none
// ============================================================================
// Module   : prj_processor_button_poller
// Brief    : Avalon-MM read master polling a 2-bit button PIO, debouncing the
//            samples and reporting press/release edges over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module prj_processor_button_poller #(
  parameter int POLL_DIV         = 50000,
  parameter int DEBOUNCE_SAMPLES = 4,
  parameter bit ACTIVE_LOW       = 1'b1,
  parameter int POLL_ADDR        = 0
) (
  input  logic        clk,
  input  logic        reset,
  output logic [1:0]  avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic [1:0]  buttons_stable,
  output logic        event_valid,
  input  logic        event_ready,
  output logic [1:0]  event_press,
  output logic [1:0]  event_release,
  output logic        event_overflow
);

  localparam int                  c_TICK_W    = $clog2(POLL_DIV);
  localparam int                  c_DB_W      = (DEBOUNCE_SAMPLES > 1) ? $clog2(DEBOUNCE_SAMPLES) : 1;
  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(POLL_DIV - 1);
  localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_SAMPLES - 1);
  localparam logic                c_IDLE_LVL  = ACTIVE_LOW;
  localparam logic [1:0]          c_ADDR      = 2'(POLL_ADDR);

  typedef enum logic [1:0] {
    S_WAIT_TICK = 2'd0,
    S_READ      = 2'd1,
    S_CAPTURE   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [c_TICK_W-1:0] r_tick_cnt;
  logic [c_TICK_W-1:0] w_tick_nxt;
  logic [1:0]          r_stable;
  logic [1:0]          w_stable_nxt;
  logic [c_DB_W-1:0]   r_db_cnt [2];
  logic [c_DB_W-1:0]   w_db_nxt [2];
  logic [1:0]          w_new_press;
  logic [1:0]          w_new_release;
  logic [1:0]          r_press;
  logic [1:0]          r_release;
  logic                r_overflow;
  logic                w_handshake;
  logic                w_unused_rdata;

  assign avm_address    = c_ADDR;
  assign avm_read       = (r_state == S_READ);
  assign buttons_stable = r_stable;
  assign event_press    = r_press;
  assign event_release  = r_release;
  assign event_overflow = r_overflow;
  assign event_valid    = |{r_press, r_release};
  assign w_handshake    = event_valid & event_ready;
  assign w_unused_rdata = ^avm_readdata[31:2];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_WAIT_TICK;
      r_tick_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick_cnt <= w_tick_nxt;
    end
  end

  // The tick counter only advances while waiting, so stalls stretch the period.
  always_comb begin
    w_state_nxt = r_state;
    w_tick_nxt  = r_tick_cnt;
    case (r_state)
      S_WAIT_TICK: begin
        if (r_tick_cnt == c_TICK_LAST) begin
          w_tick_nxt  = '0;
          w_state_nxt = S_READ;
        end else begin
          w_tick_nxt  = r_tick_cnt + 1'b1;
        end
      end
      S_READ: begin
        if (!avm_waitrequest) begin
          w_state_nxt = S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        w_state_nxt = S_WAIT_TICK;
      end
      default: begin
        w_state_nxt = S_WAIT_TICK;
      end
    endcase
  end

  always_comb begin
    w_stable_nxt  = r_stable;
    w_new_press   = 2'b00;
    w_new_release = 2'b00;
    for (int i = 0; i < 2; i++) begin
      w_db_nxt[i] = r_db_cnt[i];
      if (r_state == S_CAPTURE) begin
        if (avm_readdata[i] == r_stable[i]) begin
          w_db_nxt[i] = '0;
        end else if (r_db_cnt[i] == c_DB_LAST) begin
          w_db_nxt[i]     = '0;
          w_stable_nxt[i] = avm_readdata[i];
          if (avm_readdata[i] == c_IDLE_LVL) begin
            w_new_release[i] = 1'b1;
          end else begin
            w_new_press[i]   = 1'b1;
          end
        end else begin
          w_db_nxt[i] = r_db_cnt[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stable    <= {2{c_IDLE_LVL}};
      r_db_cnt[0] <= '0;
      r_db_cnt[1] <= '0;
    end else begin
      r_stable    <= w_stable_nxt;
      r_db_cnt[0] <= w_db_nxt[0];
      r_db_cnt[1] <= w_db_nxt[1];
    end
  end

  // An edge arriving with a handshake refills the emptied buffer instead of merging.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_press    <= 2'b00;
      r_release  <= 2'b00;
      r_overflow <= 1'b0;
    end else if (w_handshake) begin
      r_press    <= w_new_press;
      r_release  <= w_new_release;
      r_overflow <= 1'b0;
    end else begin
      r_press    <= r_press | w_new_press;
      r_release  <= r_release | w_new_release;
      r_overflow <= r_overflow | (|((r_press & w_new_press) | (r_release & w_new_release)));
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_prj_processor_button_poller.sv
`default_nettype none
// Bench: directed and randomized polls checked against a rule-level model;
// every event handshake is scoreboarded against the model's expected buffer.
module tb_prj_processor_button_poller;

  localparam int POLL_DIV = 4;
  localparam int DEB      = 3;
  localparam bit AL       = 1'b1;
  localparam int ADDR     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata = '0;
  logic [1:0]  buttons_stable;
  logic        event_valid;
  logic        event_ready;
  logic [1:0]  event_press;
  logic [1:0]  event_release;
  logic        event_overflow;

  always #5 clk = ~clk;

  prj_processor_button_poller #(
    .POLL_DIV         (POLL_DIV),
    .DEBOUNCE_SAMPLES (DEB),
    .ACTIVE_LOW       (AL),
    .POLL_ADDR        (ADDR)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .avm_address     (avm_address),
    .avm_read        (avm_read),
    .avm_waitrequest (avm_waitrequest),
    .avm_readdata    (avm_readdata),
    .buttons_stable  (buttons_stable),
    .event_valid     (event_valid),
    .event_ready     (event_ready),
    .event_press     (event_press),
    .event_release   (event_release),
    .event_overflow  (event_overflow)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [1:0] p;
    logic [1:0] r;
    logic       o;
  } ev_t;

  ev_t        exp_q[$];
  logic [1:0] btn_q[$];
  logic [1:0] last_btn  = 2'b11;
  bit         rand_mode = 1'b0;

  logic [1:0] m_stable = 2'b11;
  logic [1:0] m_press  = 2'b00;
  logic [1:0] m_rel    = 2'b00;
  logic       m_ovf    = 1'b0;
  logic [1:0] m_sample = 2'b11;
  int         m_run [2];
  bit         m_init  = 1'b0;
  bit         cap_due = 1'b0;
  int         since, exp_start, read_start, read_len, last_read_len;
  bit         in_read, acc_seen, late_flag;

  // Reference model: slave with read latency 1, debounce as a run of
  // differing samples, one-entry OR-merged event buffer, poll timing.
  initial begin : model
    bit         s_rst, s_acc, s_hs;
    logic [1:0] new_p, new_r;
    logic [31:0] rnd;
    ev_t        e;
    forever begin
      @(negedge clk);
      s_rst = reset;
      s_acc = avm_read && !avm_waitrequest;
      s_hs  = event_ready && (|{m_press, m_rel});
      chk("address", avm_address, ADDR);
      if (m_init) begin
        chk("stable", buttons_stable, m_stable);
        chk("valid", event_valid, |{m_press, m_rel});
        if (acc_seen) begin
          chk("read_in_capture", avm_read, 0);
          acc_seen = 1'b0;
        end else if (!in_read) begin
          if (avm_read) begin
            chk("read_start", since, exp_start);
            in_read    = 1'b1;
            read_start = since;
            read_len   = 0;
          end else if (since > exp_start && !late_flag) begin
            chk("read_start_late", since, exp_start);
            late_flag = 1'b1;
          end
        end
        if (in_read && !avm_read) begin
          chk("read_held", avm_read, 1);
          in_read = 1'b0;
        end else if (in_read) begin
          read_len++;
          if (!avm_waitrequest) begin
            in_read       = 1'b0;
            acc_seen      = 1'b1;
            last_read_len = read_len;
            exp_start     = read_start + POLL_DIV + read_len + 1;
          end
        end
      end
      @(posedge clk);
      if (s_rst) begin
        m_stable  = {2{AL}};
        m_press   = 2'b00;
        m_rel     = 2'b00;
        m_ovf     = 1'b0;
        m_run     = '{0, 0};
        cap_due   = 1'b0;
        since     = 0;
        exp_start = POLL_DIV;
        in_read   = 1'b0;
        acc_seen  = 1'b0;
        late_flag = 1'b0;
        m_init    = 1'b1;
      end else begin
        since++;
        new_p = 2'b00;
        new_r = 2'b00;
        if (cap_due) begin
          for (int b = 0; b < 2; b++) begin
            if (m_sample[b] == m_stable[b]) begin
              m_run[b] = 0;
            end else begin
              m_run[b]++;
              if (m_run[b] >= DEB) begin
                m_stable[b] = m_sample[b];
                m_run[b]    = 0;
                if (m_sample[b] == AL) new_r[b] = 1'b1;
                else                   new_p[b] = 1'b1;
              end
            end
          end
        end
        if (s_hs) begin
          e.p = m_press;
          e.r = m_rel;
          e.o = m_ovf;
          exp_q.push_back(e);
          m_press = new_p;
          m_rel   = new_r;
          m_ovf   = 1'b0;
        end else begin
          m_ovf   = m_ovf | (|((m_press & new_p) | (m_rel & new_r)));
          m_press = m_press | new_p;
          m_rel   = m_rel | new_r;
        end
        cap_due = s_acc;
        if (s_acc) begin
          if (btn_q.size() > 0) last_btn = btn_q.pop_front();
          else if (rand_mode && $urandom_range(3) == 0) last_btn = 2'($urandom_range(3));
          m_sample = last_btn;
        end
      end
      #1;
      rnd = $urandom();
      avm_readdata = cap_due ? {rnd[31:2], m_sample} : rnd;
    end
  end

  initial begin : monitor
    ev_t obs, e;
    forever begin
      @(negedge clk);
      if (m_init && !reset && event_valid && event_ready) begin
        obs.p = event_press;
        obs.r = event_release;
        obs.o = event_overflow;
        @(posedge clk);
        #2;
        if (exp_q.size() == 0) begin
          chk("sb_expected_present", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          chk("sb_press", obs.p, e.p);
          chk("sb_release", obs.r, e.r);
          chk("sb_overflow", obs.o, e.o);
        end
      end
    end
  end

  task automatic wait_accept();
    int t   = 0;
    bit got = 1'b0;
    while (!got && t < 200) begin
      @(negedge clk);
      t++;
      got = avm_read && !avm_waitrequest;
    end
    chk("poll_timeout", got, 1);
  endtask

  // Returns at the negedge just after the capture edge of the next poll.
  task automatic wait_poll();
    wait_accept();
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk);
    #1;
    reset = 1'b1;
    btn_q.delete();
    last_btn  = 2'b11;
    rand_mode = 1'b0;
    event_ready     = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic accept_pulse();
    @(posedge clk);
    #1 event_ready = 1'b1;
    @(posedge clk);
    #1 event_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin : stim
    int n, t;
    bit rd;
    reset = 1'b1;
    avm_waitrequest = 1'b0;
    event_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    chk("rst_stable", buttons_stable, 2'b11);
    chk("rst_read", avm_read, 0);
    chk("rst_valid", event_valid, 0);
    chk("rst_events", {event_press, event_release, event_overflow}, 0);
    n  = 1;
    rd = 1'b0;
    while (!rd && n < 20) begin
      @(negedge clk);
      if (avm_read) rd = 1'b1;
      else n++;
    end
    chk("first_read_delay", n, POLL_DIV);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!avm_read && n < 30);
    chk("poll_period", n, POLL_DIV + 2);

    // clean press on bit0
    do_reset(2);
    btn_q.push_back(2'b10);
    wait_poll();
    wait_poll();
    chk("press_early_stable", buttons_stable, 2'b11);
    chk("press_early_valid", event_valid, 0);
    wait_poll();
    chk("press_stable", buttons_stable, 2'b10);
    chk("press_bits", event_press, 2'b01);
    chk("press_release", event_release, 2'b00);
    chk("press_valid", event_valid, 1);
    accept_pulse();
    chk("press_cleared", {event_valid, event_press, event_release, event_overflow}, 0);

    // bounce rejection
    do_reset(2);
    btn_q = '{2'b11, 2'b10, 2'b11, 2'b10, 2'b10, 2'b11};
    repeat (6) wait_poll();
    chk("bounce_stable", buttons_stable, 2'b11);
    chk("bounce_valid", event_valid, 0);

    // press, release, press merged while consumer stalls
    do_reset(2);
    btn_q = '{2'b10, 2'b10, 2'b10, 2'b11, 2'b11, 2'b11, 2'b10};
    repeat (9) wait_poll();
    chk("ovf_press", event_press, 2'b01);
    chk("ovf_release", event_release, 2'b01);
    chk("ovf_flag", event_overflow, 1);
    chk("ovf_stable", buttons_stable, 2'b10);
    accept_pulse();
    chk("ovf_cleared", {event_valid, event_press, event_release, event_overflow}, 0);

    // handshake in the same cycle a new edge is captured
    do_reset(2);
    btn_q = '{2'b10, 2'b10, 2'b10, 2'b11};
    repeat (5) wait_poll();
    chk("same_pre_press", event_press, 2'b01);
    wait_accept();
    @(posedge clk);
    #1 event_ready = 1'b1;
    @(posedge clk);
    #1 event_ready = 1'b0;
    @(negedge clk);
    chk("same_press", event_press, 2'b00);
    chk("same_release", event_release, 2'b01);
    chk("same_overflow", event_overflow, 0);
    chk("same_valid", event_valid, 1);
    accept_pulse();

    // waitrequest stall of 5 cycles
    @(posedge clk);
    #1 avm_waitrequest = 1'b1;
    n = 0;
    t = 0;
    while (n < 5 && t < 100) begin
      @(negedge clk);
      t++;
      if (avm_read) n++;
    end
    @(posedge clk);
    #1 avm_waitrequest = 1'b0;
    @(negedge clk);
    chk("stall_read_held", avm_read, 1);
    @(negedge clk);
    chk("stall_capture_read", avm_read, 0);
    @(negedge clk);
    chk("stall_read_len", last_read_len, 6);

    // reset while a stalled read is in flight
    do_reset(2);
    btn_q.push_back(2'b01);
    repeat (3) wait_poll();
    chk("midrst_pending", event_press, 2'b10);
    @(posedge clk);
    #1 avm_waitrequest = 1'b1;
    t = 0;
    while (!avm_read && t < 50) begin
      @(negedge clk);
      t++;
    end
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    avm_waitrequest = 1'b0;
    last_btn = 2'b11;
    @(negedge clk);
    chk("midrst_read", avm_read, 0);
    chk("midrst_valid", event_valid, 0);
    chk("midrst_events", {event_press, event_release, event_overflow}, 0);
    chk("midrst_stable", buttons_stable, 2'b11);

    // randomized traffic
    do_reset(2);
    rand_mode = 1'b1;
    repeat (1500) begin
      @(posedge clk);
      #1;
      event_ready     = ($urandom_range(2) == 0);
      avm_waitrequest = ($urandom_range(3) == 0);
    end
    @(posedge clk);
    #1;
    rand_mode       = 1'b0;
    event_ready     = 1'b0;
    avm_waitrequest = 1'b0;
    repeat (40) @(posedge clk);
    #1 event_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 event_ready = 1'b0;
    repeat (5) @(posedge clk);
    chk("sb_leftover", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
